fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage placed directly downstream of program_counter.
//  - Reads the registered PC (pc_out) and issues it to instruction memory over a valid/ready request channel.
//  - Buffers in-order responses in a small queue and presents them to decode over a valid/ready handshake.
//  - Computes the next PC (sequential or redirect) and drives it back into program_counter.pc_in.
// PARAMETERS
//  ADDR_W    32            PC / memory address width
//  DATA_W    32            instruction width
//  QDEPTH    2             instruction queue entries; also the limit on in-flight requests
// PORTS
//  clock           in   1       rising-edge clock
//  reset           in   1       asynchronous, active-high reset
//  pc_out          in   ADDR_W  current PC from program_counter
//  pc_in           out  ADDR_W  next PC to program_counter (combinational)
//  imem_req_valid  out  1       fetch request valid
//  imem_req_addr   out  ADDR_W  fetch address (= pc_out)
//  imem_req_ready  in   1       memory accepts the request
//  imem_resp_valid in   1       response valid (in order, >=1 cycle after accept)
//  imem_resp_data  in   DATA_W  fetched instruction
//  redirect_valid  in   1       branch/jump redirect, single-cycle pulse
//  redirect_pc     in   ADDR_W  redirect target
//  inst_valid      out  1       instruction available to decode
//  inst_data       out  DATA_W  instruction
//  inst_pc         out  ADDR_W  PC of inst_data
//  inst_ready      in   1       decode accepts the instruction
// BEHAVIOUR
//  - Reset (async): queue empty, outstanding=0, stale=0, inst_valid=0, imem_req_valid=0, inst_data=0, inst_pc=0.
//  - Request:
//    - imem_req_valid = !reset && !redirect_valid && (outstanding + occupancy < QDEPTH).
//    - req_fire = valid && ready.
//    - The PC of each fired request is recorded in a QDEPTH-entry tag FIFO.
//  - Next PC:
//    - pc_in = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00} : req_fire ? pc_out+4 : pc_out.
//    - Addition is modulo 2^ADDR_W: 0xFFFFFFFC -> 0x00000000.
//  - Response:
//    - A response arriving while stale>0 is dropped; stale decrements.
//    - Otherwise the response is written to the queue with its tag PC; outstanding decrements.
//    - A response arriving while outstanding==0 && stale==0 is ignored.
//  - Output:
//    - inst_valid = queue non-empty; inst_data/inst_pc = head entry.
//    - An entry pops on inst_valid && inst_ready.
//    - Baseline latency: response at edge N -> inst_valid during cycle N+1.
//  - Redirect (on the edge where redirect_valid=1):
//    - Queue is cleared; stale <= stale + outstanding (counting any response arriving that same cycle); outstanding <= 0.
//    - A response arriving in the same cycle as the redirect is dropped.
//    - A pop in the same cycle is ignored (queue cleared).
//    - No request issues in the redirect cycle.
//  - Full: occupancy+outstanding==QDEPTH -> imem_req_valid=0 and pc_in holds pc_out.
//  - Empty: inst_valid=0; inst_data/inst_pc are don't-care.
//  - Simultaneous push and pop when full is legal (credit-limited, never overflows).
//  - Reset mid-operation discards all state immediately; pc_in is combinational, and program_counter's own reset supplies the boot PC.
// CONFIGURATION
//  FETCH_BYPASS_EN defined:
//   - When the queue is empty and a non-stale response arrives: inst_valid=imem_resp_valid, inst_data=imem_resp_data in the same cycle.
//   - If inst_ready=1, the response is consumed without being enqueued (0-cycle latency).
//   - Bypass is suppressed while redirect_valid=1.
//  FETCH_BYPASS_EN undefined: no bypass; the 1-cycle minimum latency above applies.
// TESTING
//  1. Reset: assert reset with pc_out=0x00400000, then release; memory always ready.
//     -> requests to 0x00400000, 0x00400004, ...; pc_in=pc_out+4 on each fire; inst_pc matches request order.
//  2. Backpressure: hold inst_ready=0 for 6 cycles.
//     -> exactly QDEPTH requests issue, then imem_req_valid=0; queue contents are preserved.
//  3. Redirect with 1 request outstanding: redirect_pc=0x12345679.
//     -> pc_in=0x12345678; the late response is dropped; next inst_pc=0x12345678.
//  4. Wrap-around: pc_out=0xFFFFFFFC, request fires -> pc_in=0x00000000.
//  5. Same cycle response+redirect and response+pop-when-full.
//     -> no stale instruction is seen; occupancy is never > QDEPTH.
//  6. Reset mid-stream with 2 entries queued -> inst_valid=0 immediately, outstanding=0.
//     FETCH_BYPASS_EN: an empty-queue response with inst_ready=1 appears on inst_data in the same cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: PC loop to program_counter, instruction-memory
// request/response channel, redirect input and the decode-facing handshake.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_in;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [DATA_W-1:0] imem_resp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    input  pc_out, imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready,
    output pc_in, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output pc_out, imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready,
    input  pc_in, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues pc_out to instruction memory, tracks in-flight
// requests with a tag FIFO, buffers in-order responses in a QDEPTH-entry queue
// and computes the next PC. Requests are credit-limited so that queued plus
// outstanding never exceeds QDEPTH. Responses belonging to requests issued
// before a redirect are counted as stale and dropped.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode in the same cycle when the queue is empty.
module fetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned QDEPTH = 2
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW   = $clog2(QDEPTH + 1);
  localparam int unsigned StaleW = 8;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(QDEPTH - 1);
  localparam logic [CntW:0]   Credits = (CntW + 1)'(QDEPTH);

  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [ADDR_W-1:0] pc_q   [QDEPTH];
  logic [ADDR_W-1:0] tag_q  [QDEPTH];

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [CntW-1:0]   cnt_q, cnt_d, out_q, out_d;
  logic [StaleW-1:0] stale_q, stale_d;

  logic [CntW:0] inflight;
  logic          req_valid, req_fire, resp_drop, resp_take, bypass, push, pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake decode and combinational outputs.
  always_comb begin
    inflight  = {1'b0, cnt_q} + {1'b0, out_q};
    req_valid = !reset && !bus.redirect_valid && (inflight < Credits);
    req_fire  = req_valid && bus.imem_req_ready;
    resp_drop = bus.imem_resp_valid && (stale_q != '0);
    resp_take = bus.imem_resp_valid && (stale_q == '0) && (out_q != '0) && !bus.redirect_valid;
`ifdef FETCH_BYPASS_EN
    bypass    = resp_take && (cnt_q == '0);
`else
    bypass    = 1'b0;
`endif
    pop       = (cnt_q != '0) && bus.inst_ready;
    // A bypassed response that decode accepts never enters the queue.
    push      = resp_take && !(bypass && bus.inst_ready);

    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = bus.pc_out;
    if (bus.redirect_valid) begin
      bus.pc_in = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (req_fire) begin
      bus.pc_in = bus.pc_out + ADDR_W'(4);
    end else begin
      bus.pc_in = bus.pc_out;
    end

    bus.inst_valid = (cnt_q != '0) || bypass;
    bus.inst_data  = bypass ? bus.imem_resp_data : data_q[rd_ptr_q];
    bus.inst_pc    = bypass ? tag_q[tag_rd_q]    : pc_q[rd_ptr_q];
  end

  // Next-state for queue, tag FIFO and credit counters.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    tag_rd_d = tag_rd_q;
    tag_wr_d = tag_wr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    stale_d  = stale_q;
    if (bus.redirect_valid) begin
      // Everything in flight becomes stale; a response landing this cycle
      // retires one of them immediately.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      tag_rd_d = '0;
      tag_wr_d = '0;
      cnt_d    = '0;
      out_d    = '0;
      stale_d  = stale_q + StaleW'(out_q)
               - StaleW'(bus.imem_resp_valid && ((stale_q != '0) || (out_q != '0)));
    end else begin
      if (pop)       rd_ptr_d = next_ptr(rd_ptr_q);
      if (push)      wr_ptr_d = next_ptr(wr_ptr_q);
      if (resp_take) tag_rd_d = next_ptr(tag_rd_q);
      if (req_fire)  tag_wr_d = next_ptr(tag_wr_q);
      if (resp_drop) stale_d  = stale_q - StaleW'(1);
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      out_d = out_q + CntW'(req_fire) - CntW'(resp_take);
    end
  end

  // State registers and storage writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      stale_q  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      stale_q  <= stale_d;
      if (push) begin
        data_q[wr_ptr_q] <= bus.imem_resp_data;
        pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
      end
      if (req_fire) begin
        tag_q[tag_wr_q] <= bus.pc_out;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the fetch stage. The bench plays
// program_counter (pc_out follows the expected pc_in) and instruction memory.
module tb_fetch_unit;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int QDEPTH = 2;
  localparam logic [31:0] BOOT = 32'h0040_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Stimulus knobs for the next cycle.
  logic        d_reset, d_ready, d_redir, d_inst_ready, d_resp_en;
  logic [31:0] d_redir_pc;

  // Model state.
  logic [31:0] m_data[$];
  logic [31:0] m_ipc[$];
  logic [31:0] m_tags[$];
  int          m_stale;
  logic [31:0] m_pc;

  // Memory state: accepted addresses and the cycle they were accepted in.
  logic [31:0] mem_addr[$];
  int          mem_cyc[$];
  int          cyc;

  // DUT snapshot of the last checked cycle.
  logic        s_req_valid, s_inst_valid;
  logic [31:0] s_addr, s_pc_in, s_inst_data, s_inst_pc;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check just after, update model at posedge.
  task automatic cycle();
    logic        resp_v, redir, exp_rv, fire, byp, exp_iv, act_fire;
    logic [31:0] resp_d, exp_pcin, exp_d, exp_p, tag;
    int          tot;
    @(negedge clock);
    if (d_reset) begin
      m_data.delete(); m_ipc.delete(); m_tags.delete();
      mem_addr.delete(); mem_cyc.delete();
      m_stale = 0;
      m_pc    = BOOT;
    end
    redir  = d_redir && !d_reset;
    resp_v = d_resp_en && !d_reset && (mem_addr.size() > 0) && (mem_cyc[0] < cyc);
    resp_d = resp_v ? mem_data(mem_addr[0]) : $urandom;
    reset                = d_reset;
    bus.pc_out           = m_pc;
    bus.imem_req_ready   = d_ready;
    bus.imem_resp_valid  = resp_v;
    bus.imem_resp_data   = resp_d;
    bus.redirect_valid   = redir;
    bus.redirect_pc      = d_redir_pc;
    bus.inst_ready       = d_inst_ready;
    #1;
    exp_rv   = !d_reset && !redir && (m_tags.size() + m_data.size() < QDEPTH);
    fire     = exp_rv && d_ready;
    exp_pcin = redir ? {d_redir_pc[31:2], 2'b00} : (fire ? m_pc + 32'd4 : m_pc);
    byp      = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = !d_reset && !redir && resp_v && (m_stale == 0) && (m_tags.size() > 0)
          && (m_data.size() == 0);
`endif
    exp_iv = (m_data.size() > 0) || byp;
    exp_d  = byp ? resp_d    : (m_data.size() > 0 ? m_data[0] : 32'h0);
    exp_p  = byp ? m_tags[0] : (m_ipc.size() > 0 ? m_ipc[0] : 32'h0);

    s_req_valid  = bus.imem_req_valid;
    s_addr       = bus.imem_req_addr;
    s_pc_in      = bus.pc_in;
    s_inst_valid = bus.inst_valid;
    s_inst_data  = bus.inst_data;
    s_inst_pc    = bus.inst_pc;
    act_fire     = s_req_valid && d_ready;

    chk("req_valid", {31'b0, s_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", s_addr, m_pc);
    chk("pc_in", s_pc_in, exp_pcin);
    chk("inst_valid", {31'b0, s_inst_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      chk("inst_data", s_inst_data, exp_d);
      chk("inst_pc", s_inst_pc, exp_p);
    end

    @(posedge clock);
    if (resp_v) begin
      void'(mem_addr.pop_front());
      void'(mem_cyc.pop_front());
    end
    if (act_fire) begin
      mem_addr.push_back(s_addr);
      mem_cyc.push_back(cyc);
    end
    cyc++;
    if (d_reset) begin
      m_pc = BOOT;
    end else if (redir) begin
      tot = m_stale + m_tags.size();
      m_stale = (resp_v && tot > 0) ? tot - 1 : tot;
      m_data.delete(); m_ipc.delete(); m_tags.delete();
      m_pc = exp_pcin;
    end else begin
      if ((m_data.size() > 0) && d_inst_ready) begin
        void'(m_data.pop_front());
        void'(m_ipc.pop_front());
      end
      if (resp_v) begin
        if (m_stale > 0) begin
          m_stale--;
        end else if (m_tags.size() > 0) begin
          tag = m_tags.pop_front();
          if (!(byp && d_inst_ready)) begin
            m_data.push_back(resp_d);
            m_ipc.push_back(tag);
          end
        end
      end
      if (fire) m_tags.push_back(m_pc);
      m_pc = exp_pcin;
    end
  endtask

  // Run until decode sees an instruction; its PC must be exp_pc.
  task automatic wait_inst(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_inst_valid) begin
        chk(name, s_inst_pc, exp_pc);
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: no instruction within 20 cycles, expected pc %h", name, exp_pc);
  endtask

  task automatic do_reset();
    d_reset = 1'b1;
    d_redir = 1'b0;
    cycle();
    d_reset = 1'b0;
  endtask

  initial begin
    int nf;
    bus.pc_out = BOOT; bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.inst_ready = 1'b0;
    m_stale = 0; m_pc = BOOT; cyc = 0;
    d_reset = 1'b1; d_ready = 1'b1; d_redir = 1'b0; d_inst_ready = 1'b1;
    d_resp_en = 1'b1; d_redir_pc = '0;

    // Reset state and sequential fetch from the boot PC.
    cycle();
    cycle();
    chk("rst_inst_valid", {31'b0, s_inst_valid}, 32'd0);
    chk("rst_req_valid", {31'b0, s_req_valid}, 32'd0);
    chk("rst_inst_data", s_inst_data, 32'h0);
    chk("rst_inst_pc", s_inst_pc, 32'h0);
    d_reset = 1'b0;
    cycle();
    chk("t1_addr0", s_addr, 32'h0040_0000);
    chk("t1_pc_in0", s_pc_in, 32'h0040_0004);
    wait_inst("t1_first_pc", 32'h0040_0000);
    wait_inst("t1_second_pc", 32'h0040_0004);

    // Backpressure: exactly QDEPTH requests, then stall with contents kept.
    do_reset();
    d_inst_ready = 1'b0;
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_req_valid) nf++;
    end
    chk("t2_fires", nf, 32'd2);
    chk("t2_req_stalled", {31'b0, s_req_valid}, 32'd0);
    chk("t2_head_pc", s_inst_pc, 32'h0040_0000);
    d_inst_ready = 1'b1;
    repeat (4) cycle();

    // Redirect with one request outstanding; its late response is dropped.
    do_reset();
    d_resp_en = 1'b0;
    cycle();
    d_redir = 1'b1; d_redir_pc = 32'h1234_5679;
    cycle();
    chk("t3_pc_in", s_pc_in, 32'h1234_5678);
    chk("t3_no_req", {31'b0, s_req_valid}, 32'd0);
    d_redir = 1'b0; d_resp_en = 1'b1;
    wait_inst("t3_first_pc", 32'h1234_5678);

    // Wrap-around of the sequential PC.
    d_redir = 1'b1; d_redir_pc = 32'hFFFF_FFFC;
    cycle();
    d_redir = 1'b0;
    cycle();
    chk("t4_addr", s_addr, 32'hFFFF_FFFC);
    chk("t4_pc_in", s_pc_in, 32'h0000_0000);
    repeat (4) cycle();

    // Response in the redirect cycle is dropped; then fill and drain at full.
    do_reset();
    d_resp_en = 1'b0;
    cycle();
    d_resp_en = 1'b1; d_redir = 1'b1; d_redir_pc = 32'h0000_1000;
    cycle();
    d_redir = 1'b0;
    wait_inst("t5_first_pc", 32'h0000_1000);
    d_inst_ready = 1'b0;
    repeat (4) cycle();
    d_inst_ready = 1'b1;
    repeat (4) cycle();

    // Reset with two entries queued clears the output immediately.
    do_reset();
    d_inst_ready = 1'b0;
    repeat (5) cycle();
    chk("t6_full_valid", {31'b0, s_inst_valid}, 32'd1);
    d_reset = 1'b1;
    cycle();
    chk("t6_rst_valid", {31'b0, s_inst_valid}, 32'd0);
    chk("t6_rst_req", {31'b0, s_req_valid}, 32'd0);
    d_reset = 1'b0; d_inst_ready = 1'b1;
    repeat (3) cycle();

`ifdef FETCH_BYPASS_EN
    // Empty-queue response reaches decode in the same cycle.
    do_reset();
    d_resp_en = 1'b0;
    cycle();
    d_resp_en = 1'b1; d_ready = 1'b0;
    cycle();
    chk("byp_valid", {31'b0, s_inst_valid}, 32'd1);
    chk("byp_data", s_inst_data, mem_data(32'h0040_0000));
    d_ready = 1'b1;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      d_reset      = ($urandom_range(0, 199) == 0);
      d_ready      = ($urandom_range(0, 3) != 0);
      d_inst_ready = ($urandom_range(0, 9) < 6);
      d_resp_en    = ($urandom_range(0, 9) < 6);
      d_redir      = ($urandom_range(0, 19) == 0);
      d_redir_pc   = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
